sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_pkg.sv | 18 +
 rtl/sweep_golden.sv | 12 +
 rtl/sweep_ctrl.sv | 122 ++++++++++++
 tb/tb_sweep_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package sweep_pkg;

  localparam int VEC_W = 4;
  localparam int NUM_VEC = 16;
  localparam int ERR_W = 5;

  // Expected truth table of F = (A & ~B) | (~C & D), bit i for vec == i.
  localparam logic [NUM_VEC-1:0] GOLDEN_TT = 16'h2F22;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/sweep_golden.sv
// Combinational reference model of the function unit: F = (A & ~B) | (~C & D).
module sweep_golden
  import sweep_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             f
);

  // A is the MSB of vec, D the LSB.
  assign f = (vec[3] & ~vec[2]) | (~vec[1] & vec[0]);

endmodule

// File: rtl/sweep_ctrl.sv
// Exhaustive 16-vector sweep of a 4-input function unit, capturing its truth table.
// Optional on-line checker against the golden model is enabled by SWEEP_CHECK_EN.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [VEC_W-1:0]   vec,
  input  logic               f_in,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] truth_table,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [VEC_W-1:0]   first_fail
);

  localparam logic [VEC_W-1:0] SETTLE_LAST = VEC_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] idx;
  logic [VEC_W-1:0] cnt;
  logic             accept;
  logic             sample_we;

  assign accept    = (state == IDLE) && start;
  // abort wins over the capture in the same cycle.
  assign sample_we = (state == SAMPLE) && !abort;

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE: begin
        if (abort)                    state_nxt = IDLE;
        else if (cnt == SETTLE_LAST)  state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                    state_nxt = IDLE;
        else if (idx == LAST_IDX)     state_nxt = DONE;
        else                          state_nxt = SETTLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: truth_table is a 16-bit register, not a memory, so it is reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      truth_table <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx         <= '0;
        cnt         <= '0;
        truth_table <= '0;
      end else if (state == SETTLE) begin
        cnt <= cnt + 4'd1;
      end else if (sample_we) begin
        truth_table[idx] <= f_in;
        // idx parks at the last vector on the way into DONE.
        if (idx != LAST_IDX) begin
          idx <= idx + 4'd1;
          cnt <= '0;
        end
      end
    end
  end

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign vec  = busy ? idx : '0;

`ifdef SWEEP_CHECK_EN
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(NUM_VEC);

  logic golden_f;
  logic mismatch;

  sweep_golden u_golden (
    .vec (idx),
    .f   (golden_f)
  );

  assign mismatch = sample_we && (f_in != golden_f);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (accept) begin
      err_cnt    <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 5'd1;
        if (err_cnt == '0)      first_fail <= idx;
      end
      // The final sample's own comparison must count toward pass.
      if (sample_we && (idx == LAST_IDX)) pass <= (err_cnt == '0) && !mismatch;
    end
  end
`else
  assign pass       = 1'b0;
  assign err_cnt    = '0;
  assign first_fail = '0;
`endif

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: scoreboarded sweeps, abort, reset and start filtering.
module tb_sweep_ctrl;
  import sweep_pkg::*;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        pass;
    int          edge_n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sel, start_x, abort_x;
  int   mode;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  logic        start_a, abort_a, f_a, busy_a, done_a, pass_a;
  logic        start_b, abort_b, f_b, busy_b, done_b, pass_b;
  logic [3:0]  vec_a, ff_a, vec_b, ff_b;
  logic [15:0] tt_a, tt_b;
  logic [4:0]  err_a, err_b;

  function automatic logic model_f(input logic [3:0] v);
    return (v[3] & ~v[2]) | (~v[1] & v[0]);
  endfunction

  // Function-unit stand-in: 0 correct, 1 stuck at 0, 2 inverted.
  function automatic logic unit_f(input logic [3:0] v, input int m);
    case (m)
      1:       return 1'b0;
      2:       return ~model_f(v);
      default: return model_f(v);
    endcase
  endfunction

  assign start_a = start_x & ~sel;
  assign abort_a = abort_x & ~sel;
  assign start_b = start_x & sel;
  assign abort_b = abort_x & sel;
  assign f_a = unit_f(vec_a, mode);
  assign f_b = unit_f(vec_b, mode);

  sweep_ctrl #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .vec(vec_a), .f_in(f_a),
    .busy(busy_a), .done(done_a), .truth_table(tt_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail(ff_a)
  );

  sweep_ctrl #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .vec(vec_b), .f_in(f_b),
    .busy(busy_b), .done(done_b), .truth_table(tt_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail(ff_b)
  );

  logic [3:0]  o_vec, o_ff;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_err;
  assign o_vec  = sel ? vec_b  : vec_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;
  assign o_tt   = sel ? tt_b   : tt_a;
  assign o_err  = sel ? err_b  : err_a;
  assign o_ff   = sel ? ff_b   : ff_a;

  // Caller must be at a negedge; the following posedge accepts start.
  task automatic run_sweep(input logic s, input int m, input int settle, input int extra_start);
    exp_t e, got;
    int   nerr, dones, bad, last_n;
    logic found;
    logic [3:0] ev;
    logic [3:0] vq[$];
    sel = s;
    mode = m;
    e.tt = '0; e.ff = '0; nerr = 0; found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e.tt[i] = unit_f(4'(i), m);
      if (e.tt[i] != model_f(4'(i))) begin
        nerr++;
        if (!found) begin e.ff = 4'(i); found = 1'b1; end
      end
    end
`ifdef SWEEP_CHECK_EN
    e.err  = 5'((nerr > 16) ? 16 : nerr);
    e.pass = (nerr == 0);
`else
    e.err  = '0;
    e.ff   = '0;
    e.pass = 1'b0;
`endif
    last_n = 16 * (settle + 1);
    e.edge_n = last_n;
    sb.push_back(e);
    for (int n = 0; n < last_n; n++) vq.push_back(4'(n / (settle + 1)));
    vq.push_back(4'h0);

    start_x = 1'b1;
    @(negedge clk);
    start_x = 1'b0;
    dones = 0;
    bad = 0;
    for (int n = 0; n <= last_n + 16; n++) begin
      if (n > 0) @(negedge clk);
      if (vq.size() > 0) begin
        ev = vq.pop_front();
        if (o_vec !== ev || o_busy !== (n < last_n)) begin
          if (bad == 0)
            $display("FAIL vec_seq edge %0d: vec=%h busy=%b, expected vec=%h busy=%b",
                     n, o_vec, o_busy, ev, (n < last_n));
          bad++;
        end
      end
      if (o_done === 1'b1) begin
        dones++;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_done at edge %0d", n);
        end else begin
          got = sb.pop_front();
          tests++;
          if (n !== got.edge_n) begin
            fails++; $display("FAIL done_latency: edge %0d, expected %0d", n, got.edge_n);
          end
          tests++;
          if (o_tt !== got.tt) begin
            fails++; $display("FAIL truth_table: got %h, expected %h", o_tt, got.tt);
          end
          tests++;
          if (o_err !== got.err) begin
            fails++; $display("FAIL err_cnt: got %0d, expected %0d", o_err, got.err);
          end
          tests++;
          if (o_ff !== got.ff) begin
            fails++; $display("FAIL first_fail: got %0d, expected %0d", o_ff, got.ff);
          end
          tests++;
          if (o_pass !== got.pass) begin
            fails++; $display("FAIL pass: got %b, expected %b", o_pass, got.pass);
          end
        end
      end
      start_x = (n == extra_start);
    end
    start_x = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL vec_seq: %0d bad cycles, expected 0", bad);
    end
    tests++;
    if (dones != 1) begin
      fails++; $display("FAIL done_count: got %0d pulses, expected 1", dones);
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: %0d results never produced", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({vec_a, busy_a, done_a, tt_a, pass_a, err_a, ff_a} !== 32'h0) begin
      fails++; $display("FAIL reset_a: outputs %h, expected 0",
                        {vec_a, busy_a, done_a, tt_a, pass_a, err_a, ff_a});
    end
    tests++;
    if ({vec_b, busy_b, done_b, tt_b, pass_b, err_b, ff_b} !== 32'h0) begin
      fails++; $display("FAIL reset_b: outputs %h, expected 0",
                        {vec_b, busy_b, done_b, tt_b, pass_b, err_b, ff_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_golden_sweep();
    run_sweep(1'b0, 0, 1, -1);
    tests++;
    if (tt_a !== GOLDEN_TT) begin
      fails++; $display("FAIL golden_tt: got %h, expected %h", tt_a, GOLDEN_TT);
    end
  endtask

  task automatic test_hold();
    logic [15:0] tt_exp;
    tt_exp = GOLDEN_TT;
    sel = 1'b0;
    abort_x = 1'b1;
    repeat (3) @(negedge clk);
    abort_x = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (tt_a !== tt_exp || busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++; $display("FAIL hold_idle: tt=%h busy=%b done=%b, expected tt=%h busy=0 done=0",
                        tt_a, busy_a, done_a, tt_exp);
    end
  endtask

  task automatic test_abort();
    int   waited, dones;
    sel = 1'b0;
    mode = 0;
    start_x = 1'b1;
    @(negedge clk);
    start_x = 1'b0;
    waited = 0;
    while (vec_a !== 4'h8 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (vec_a !== 4'h8) begin
      fails++; $display("FAIL abort_wait: vec=%h, expected 8 within 64 cycles", vec_a);
    end else begin
      // Second cycle at vec 8 is SAMPLE; abort must block the bit-8 write.
      @(negedge clk);
      abort_x = 1'b1;
      @(negedge clk);
      abort_x = 1'b0;
      tests++;
      if (busy_a !== 1'b0 || vec_a !== 4'h0 || done_a !== 1'b0) begin
        fails++; $display("FAIL abort_idle: busy=%b vec=%h done=%b, expected 0 0 0",
                          busy_a, vec_a, done_a);
      end
      tests++;
      if (tt_a !== 16'h0022) begin
        fails++; $display("FAIL abort_partial_tt: got %h, expected 0022", tt_a);
      end
      dones = 0;
      repeat (40) begin
        @(negedge clk);
        if (done_a === 1'b1) dones++;
      end
      tests++;
      if (dones != 0) begin
        fails++; $display("FAIL abort_no_done: got %0d pulses, expected 0", dones);
      end
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    sel = 1'b0;
    mode = 0;
    start_x = 1'b1;
    @(negedge clk);
    start_x = 1'b0;
    waited = 0;
    while (vec_a !== 4'h5 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (vec_a !== 4'h5) begin
      fails++; $display("FAIL reset_mid_wait: vec=%h, expected 5 within 64 cycles", vec_a);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({vec_a, busy_a, done_a, tt_a, pass_a, err_a, ff_a} !== 32'h0) begin
      fails++; $display("FAIL reset_mid: outputs %h, expected 0",
                        {vec_a, busy_a, done_a, tt_a, pass_a, err_a, ff_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // start is presented for the very first edge after reset release.
    run_sweep(1'b0, 0, 1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    start_x = 1'b0;
    abort_x = 1'b0;
    mode = 0;
    test_reset();
    test_golden_sweep();
    test_hold();
    run_sweep(1'b0, 1, 1, -1);
    run_sweep(1'b0, 2, 1, -1);
    run_sweep(1'b1, 0, 3, 10);
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
